// File: rtl/ecc_smul_seq_pkg.sv
// Shared encodings for the ECC scalar-multiplication sequencer: point-op codes,
// FSM state type and a small ladder op-selection helper.
package ecc_pkg;

    localparam logic [2:0] EC_LOAD = 3'd0;
    localparam logic [2:0] EC_DBL  = 3'd1;
    localparam logic [2:0] EC_ADD  = 3'd2;
    localparam logic [2:0] EC_LAD0 = 3'd3;
    localparam logic [2:0] EC_LAD1 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [2:0] lad_op(input logic kbit);
        return kbit ? EC_LAD1 : EC_LAD0;
    endfunction

endpackage

// File: rtl/ecc_smul_seq_if.sv
// Op-issue handshake between the scalar sequencer (master) and the EC point engine (slave).
interface ecc_smul_seq_if;

    logic       ec_en;
    logic [2:0] ec_op;
    logic       ec_rdy;

    modport master (output ec_en, output ec_op, input ec_rdy);
    modport slave  (input ec_en, input ec_op, output ec_rdy);

endinterface

// File: rtl/ecc_smul_seq_cnt.sv
// Performance counters for the sequencer: total issued ops and DBL ops.
// Instantiated only when ECC_SMUL_PERF_EN is defined.
module ecc_smul_cnt #(
    parameter int OW = 10,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc_op,
    input  logic          inc_dbl,
    output logic [OW-1:0] op_cnt,
    output logic [DW-1:0] dbl_cnt
);

    logic [OW-1:0] op_cnt_r;
    logic [DW-1:0] dbl_cnt_r;

    // Counters restart on every accepted start and simply stop moving once no more ops issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_r  <= '0;
            dbl_cnt_r <= '0;
        end else if (clear) begin
            op_cnt_r  <= '0;
            dbl_cnt_r <= '0;
        end else begin
            if (inc_op) begin
                op_cnt_r <= op_cnt_r + OW'(1);
            end
            if (inc_dbl) begin
                dbl_cnt_r <= dbl_cnt_r + DW'(1);
            end
        end
    end

    assign op_cnt  = op_cnt_r;
    assign dbl_cnt = dbl_cnt_r;

endmodule

// File: rtl/ecc_smul_seq.sv
// Scalar-multiplication sequencer: scans a KW-bit scalar and issues LOAD/DBL/ADD/LAD ops
// one at a time. Optional counters (op_cnt, dbl_cnt) are enabled by ECC_SMUL_PERF_EN.
module ecc_smul_seq
    import ecc_pkg::*;
#(
    parameter  int KW = 256,
    localparam int IW = $clog2(KW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clr,
    input  logic            mode,
    input  logic [KW-1:0]   scalar,
    ecc_smul_seq_if.master  ec,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [IW-1:0]   bit_idx
`ifdef ECC_SMUL_PERF_EN
    ,
    output logic [IW+1:0]   op_cnt,
    output logic [IW:0]     dbl_cnt
`endif
);

    localparam logic [IW-1:0] IDX_TOP = IW'(KW - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    state_e        state_r;
    logic [KW-1:0] k_r;
    logic          m_r;
    logic [IW-1:0] bit_idx_r;
    logic [2:0]    op_r;
    logic          ec_en_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic [IW-1:0] idx_dn_s;

    assign idx_dn_s = bit_idx_r - IDX_ONE;

    // Main sequencer FSM: scalar scan, op issue, completion wait and done/err reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            k_r       <= '0;
            m_r       <= 1'b0;
            bit_idx_r <= '0;
            op_r      <= EC_LOAD;
            ec_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else if (clr) begin
            state_r   <= ST_IDLE;
            bit_idx_r <= '0;
            op_r      <= EC_LOAD;
            ec_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ec_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        k_r       <= scalar;
                        m_r       <= mode;
                        bit_idx_r <= IDX_TOP;
                        busy_r    <= 1'b1;
                        err_r     <= 1'b0;
                        state_r   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Ladder needs the top bit set so that every scalar costs exactly KW ops.
                    if (m_r) begin
                        if (k_r[KW-1]) begin
                            op_r    <= EC_LOAD;
                            ec_en_r <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end
                    end else if (k_r[bit_idx_r]) begin
                        op_r    <= EC_LOAD;
                        ec_en_r <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else if (bit_idx_r == '0) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        bit_idx_r <= idx_dn_s;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ec.ec_rdy) begin
                        if (!m_r && (op_r == EC_DBL) && k_r[bit_idx_r]) begin
                            op_r    <= EC_ADD;
                            ec_en_r <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else if (bit_idx_r == '0) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            bit_idx_r <= idx_dn_s;
                            op_r      <= m_r ? lad_op(k_r[idx_dn_s]) : EC_DBL;
                            ec_en_r   <= 1'b1;
                            state_r   <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ec.ec_en = ec_en_r;
    assign ec.ec_op = op_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign bit_idx  = bit_idx_r;

`ifdef ECC_SMUL_PERF_EN
    logic start_acc_s;
    logic inc_dbl_s;

    assign start_acc_s = start && !clr && (state_r == ST_IDLE);
    assign inc_dbl_s   = ec_en_r && (op_r == EC_DBL);

    ecc_smul_cnt #(
        .OW (IW + 2),
        .DW (IW + 1)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_acc_s),
        .inc_op  (ec_en_r),
        .inc_dbl (inc_dbl_s),
        .op_cnt  (op_cnt),
        .dbl_cnt (dbl_cnt)
    );
`endif

endmodule

// File: tb/tb_ecc_smul_seq.sv
// Directed self-checking bench for ecc_smul_seq (KW=8) with a 3-cycle point-engine model
// and a scoreboard of expected op sequences.
module tb_ecc_smul_seq;
    import ecc_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] op;
    } obs_t;

    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clr;
    logic       mode;
    logic [7:0] scalar;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] bit_idx;
`ifdef ECC_SMUL_PERF_EN
    logic [4:0] op_cnt;
    logic [3:0] dbl_cnt;
`endif

    ecc_smul_seq_if ec_bus ();

    ecc_smul_seq #(.KW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clr     (clr),
        .mode    (mode),
        .scalar  (scalar),
        .ec      (ec_bus),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bit_idx (bit_idx)
`ifdef ECC_SMUL_PERF_EN
        ,
        .op_cnt  (op_cnt),
        .dbl_cnt (dbl_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          eng_cnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [2:0]  exp_q[$];
    obs_t        obs_q[$];
    done_t       done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Point engine: answers each op with a one-cycle ec_rdy three cycles after ec_en.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            ec_bus.ec_rdy <= 1'b0;
            eng_cnt       <= 0;
        end else begin
            ec_bus.ec_rdy <= 1'b0;
            if (ec_bus.ec_en === 1'b1) begin
                eng_cnt <= 2;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) ec_bus.ec_rdy <= 1'b1;
            end
        end
    end

    // Output monitor: records every issued op and every done pulse with its cycle.
    always @(negedge clk) begin
        if (ec_bus.ec_en === 1'b1) obs_q.push_back('{cyc, ec_bus.ec_op});
        if (done === 1'b1) done_q.push_back('{cyc, err});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference op sequence of the two scalar-multiplication algorithms.
    task automatic expect_ops(input logic m, input logic [7:0] k,
                              output int n, output logic e, output int msb);
        msb = -1;
        n   = 0;
        for (int i = 7; i >= 0; i--) if (k[i] && msb < 0) msb = i;
        if (m) begin
            if (!k[7]) begin
                e = 1'b1;
            end else begin
                e = 1'b0;
                exp_q.push_back(EC_LOAD); n++;
                for (int i = 6; i >= 0; i--) begin
                    exp_q.push_back(k[i] ? EC_LAD1 : EC_LAD0); n++;
                end
            end
        end else if (msb < 0) begin
            e = 1'b1;
        end else begin
            e = 1'b0;
            exp_q.push_back(EC_LOAD); n++;
            for (int i = msb - 1; i >= 0; i--) begin
                exp_q.push_back(EC_DBL); n++;
                if (k[i]) begin exp_q.push_back(EC_ADD); n++; end
            end
        end
    endtask

    task automatic run_case(input string tag, input logic m, input logic [7:0] k,
                            input int poke, output int issue_to_done);
        int   n;
        int   msb;
        int   s_cyc;
        int   f_cyc;
        logic e;
        logic got;
        obs_t  o;
        done_t d;
        exp_q.delete(); obs_q.delete(); done_q.delete();
        expect_ops(m, k, n, e, msb);
        issue_to_done = -1;
        f_cyc  = -1;
        got    = 1'b0;
        mode   = m;
        scalar = k;
        start  = 1'b1;
        s_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done === 1'b1) begin got = 1'b1; break; end
            if (i == poke) begin
                start  = 1'b1;
                scalar = ~k;
                mode   = ~m;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_n_ops"}, obs_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (i == 0) f_cyc = o.cyc;
                chk({tag, "_op"}, {29'd0, o.op}, {29'd0, exp_q.pop_front()});
            end
        end
        chk({tag, "_n_done"}, done_q.size(), 32'd1);
        if (done_q.size() > 0) begin
            d = done_q.pop_front();
            if (n > 0) begin
                chk({tag, "_first_issue"}, f_cyc - s_cyc, 9 - msb);
                issue_to_done = d.cyc - f_cyc;
                chk({tag, "_issue_to_done"}, issue_to_done, 4 * n);
            end else begin
                chk({tag, "_err_latency"}, d.cyc - s_cyc, m ? 2 : 9);
            end
        end
    endtask

    initial begin
        int   t_a;
        int   t_b;
        int   n_en;
        logic hit;
        rst = 1'b1; start = 1'b0; clr = 1'b0; mode = 1'b0; scalar = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ec_en", {31'd0, ec_bus.ec_en}, 32'd0);
        chk("rst_bit_idx", {29'd0, bit_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_case("t1", 1'b0, 8'b0000_1011, -1, t_a);
`ifdef ECC_SMUL_PERF_EN
        chk("t1_op_cnt", {27'd0, op_cnt}, 32'd6);
        chk("t1_dbl_cnt", {28'd0, dbl_cnt}, 32'd3);
`endif
        run_case("t2a", 1'b0, 8'h00, -1, t_a);
        run_case("t2b", 1'b0, 8'h01, -1, t_a);
        run_case("t3a", 1'b1, 8'b1010_0110, -1, t_a);
`ifdef ECC_SMUL_PERF_EN
        chk("t3_op_cnt", {27'd0, op_cnt}, 32'd8);
        chk("t3_dbl_cnt", {28'd0, dbl_cnt}, 32'd0);
`endif
        run_case("t3b", 1'b1, 8'hFF, -1, t_b);
        chk("t3_const_time", t_a, t_b);
        run_case("t4", 1'b1, 8'h7F, -1, t_a);

        // Abort two cycles into the WAIT of the third op; its ec_rdy still arrives.
        exp_q.delete(); obs_q.delete(); done_q.delete();
        mode = 1'b0; scalar = 8'b0000_1011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_en = 0;
        hit  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ec_bus.ec_en === 1'b1) n_en++;
            if (n_en == 3) begin hit = 1'b1; break; end
        end
        chk("t5_third_issue", {31'd0, hit}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_ec_en", {31'd0, ec_bus.ec_en}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t5_no_done", done_q.size(), 32'd0);
        chk("t5_ops_before_abort", obs_q.size(), 32'd3);
        run_case("t5b", 1'b0, 8'b0000_1011, -1, t_a);

        run_case("t6a", 1'b0, 8'b0000_1011, 3, t_a);

        // Reset in the middle of a ladder run.
        exp_q.delete(); obs_q.delete(); done_q.delete();
        mode = 1'b1; scalar = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_err", {31'd0, err}, 32'd0);
        chk("t6_rst_ec_en", {31'd0, ec_bus.ec_en}, 32'd0);
        chk("t6_rst_ec_op", {29'd0, ec_bus.ec_op}, 32'd0);
        chk("t6_rst_bit_idx", {29'd0, bit_idx}, 32'd0);
`ifdef ECC_SMUL_PERF_EN
        chk("t6_rst_op_cnt", {27'd0, op_cnt}, 32'd0);
`endif
        obs_q.delete(); done_q.delete();
        repeat (6) @(negedge clk);
        chk("t6_rst_quiet", obs_q.size(), 32'd0);

        // start together with clr is dropped.
        mode = 1'b0; scalar = 8'h01; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        chk("t7_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("t7_no_ops", obs_q.size(), 32'd0);
        chk("t7_no_done", done_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
